// File: rtl/regfile_param.sv
// Parametrised register file: 2 registered read ports, 1 write port, hardwired zero entry, clear sweeper (REGFILE_BYPASS_EN: write-first forwarding).
// Latency: reads 1 cycle; sweep keeps busy high for DEPTH cycles, then clr_done pulses for 1 cycle.
// Backpressure: none; writes arriving while busy are discarded and flagged on wr_drop one cycle later.
module regfile_param #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    // Entry 0 has no storage: it always reads as zero.
    logic [WIDTH-1:0]  mem_q [1:DEPTH-1];
    logic [WIDTH-1:0]  rd_data1_q, rd_data1_d;
    logic [WIDTH-1:0]  rd_data2_q, rd_data2_d;
    logic              wr_drop_q, wr_drop_d;
    logic              wr_ok;

    assign busy     = (state_q == ST_SWEEP);
    assign clr_done = (state_q == ST_DONE);
    assign wr_drop  = wr_drop_q;
    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;

    assign wr_ok     = wr_en && !busy && (wr_addr != '0) && ({1'b0, wr_addr} < DEPTH_W);
    assign wr_drop_d = wr_en && busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data1_d = '0;
        rd_data2_d = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (rd_addr1 == ADDR_W'(i)) rd_data1_d = mem_q[i];
            if (rd_addr2 == ADDR_W'(i)) rd_data2_d = mem_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr1)) rd_data1_d = wr_data;
        if (wr_ok && (wr_addr == rd_addr2)) rd_data2_d = wr_data;
`endif
    end

    // Sweep and port writes never coincide: wr_ok is qualified with !busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (busy && (cnt_q == ADDR_W'(i))) begin
                    mem_q[i] <= '0;
                end else if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                    mem_q[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a 32-entry and a 20-entry instance share stimulus, each tracked by its own reference model.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr;
    logic [31:0] wr_data;
    logic        wr_en, clr_req;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, done_a, drop_a, busy_b, done_b, drop_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut_a (
        .clk(clk), .rst_n(rst_a_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_a), .rd_data2(rd2_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy_a), .clr_done(done_a), .wr_drop(drop_a)
    );

    regfile_param #(.WIDTH(32), .DEPTH(20), .ADDR_W(5)) dut_b (
        .clk(clk), .rst_n(rst_b_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_b), .rd_data2(rd2_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy_b), .clr_done(done_b), .wr_drop(drop_b)
    );

    // Reference model: plain array contents plus "sweep active / position" bookkeeping.
    int          m_dep [2] = '{32, 20};
    logic [31:0] m_mem [2][32];
    bit          m_busy [2];
    bit          m_done [2];
    bit          m_drop [2];
    int          m_pos [2];
    logic [31:0] m_rd1 [2];
    logic [31:0] m_rd2 [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        for (int i = 0; i < 32; i++) m_mem[d][i] = 32'h0;
        m_busy[d] = 1'b0;
        m_done[d] = 1'b0;
        m_drop[d] = 1'b0;
        m_pos[d]  = 0;
        m_rd1[d]  = 32'h0;
        m_rd2[d]  = 32'h0;
    endtask

    task automatic model_edge(input int d);
        int          dd;
        bit          valid;
        logic [31:0] n1, n2;
        dd    = m_dep[d];
        valid = wr_en && !m_busy[d] && (wr_addr != 5'd0) && (int'(wr_addr) < dd);
        n1 = (rd_addr1 != 5'd0 && int'(rd_addr1) < dd) ? m_mem[d][rd_addr1] : 32'h0;
        n2 = (rd_addr2 != 5'd0 && int'(rd_addr2) < dd) ? m_mem[d][rd_addr2] : 32'h0;
        if (BYP && valid && wr_addr == rd_addr1) n1 = wr_data;
        if (BYP && valid && wr_addr == rd_addr2) n2 = wr_data;
        m_drop[d] = wr_en && m_busy[d];
        if (m_busy[d]) begin
            m_mem[d][m_pos[d]] = 32'h0;
            if (m_pos[d] == dd - 1) begin
                m_busy[d] = 1'b0;
                m_done[d] = 1'b1;
            end else begin
                m_pos[d]++;
            end
        end else if (m_done[d]) begin
            m_done[d] = 1'b0;
        end else if (clr_req) begin
            m_busy[d] = 1'b1;
            m_pos[d]  = 0;
        end
        if (valid) m_mem[d][wr_addr] = wr_data;
        m_rd1[d] = n1;
        m_rd2[d] = n2;
    endtask

    task automatic compare_all();
        chk("rd1_a", rd1_a, m_rd1[0]);
        chk("rd2_a", rd2_a, m_rd2[0]);
        chk("busy_a", 32'(busy_a), 32'(m_busy[0]));
        chk("clr_done_a", 32'(done_a), 32'(m_done[0]));
        chk("wr_drop_a", 32'(drop_a), 32'(m_drop[0]));
        chk("rd1_b", rd1_b, m_rd1[1]);
        chk("rd2_b", rd2_b, m_rd2[1]);
        chk("busy_b", 32'(busy_b), 32'(m_busy[1]));
        chk("clr_done_b", 32'(done_b), 32'(m_done[1]));
        chk("wr_drop_b", 32'(drop_b), 32'(m_drop[1]));
    endtask

    task automatic step();
        if (rst_a_n) model_edge(0);
        if (rst_b_n) model_edge(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic fill_index();
        for (int i = 1; i < 32; i++) begin
            wr_en    = 1'b1;
            wr_addr  = 5'(i);
            wr_data  = 32'(i);
            rd_addr1 = 5'($urandom_range(31));
            rd_addr2 = 5'($urandom_range(31));
            step();
        end
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int na, nb, da, db;
        tbl[0] = '{1'b1, 5'd3,  32'hABCDEF12, 5'd1,  5'd2,  32'h0, 32'h0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'hABCDEF12, 32'hABCDEF12};
        tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd3,  32'h0, 32'hABCDEF12};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
        tbl[4] = '{1'b1, 5'd5,  32'hAAAA5555, 5'd9,  5'd9,  32'h0, 32'h0};
        tbl[5] = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd5,
                   BYP ? 32'h12345678 : 32'hAAAA5555, BYP ? 32'h12345678 : 32'hAAAA5555};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd3,  32'h12345678, 32'hABCDEF12};
        tbl[7] = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd31,
                   BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 32'hDEADBEEF, 32'h0};

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        wr_en = 1'b0; clr_req = 1'b0;
        wr_addr = 5'd0; wr_data = 32'h0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        model_reset(0);
        model_reset(1);
        #3;
        compare_all();
        @(posedge clk);
        #1;
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            step();
        end

        for (int i = 0; i < 9; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rd_addr1 = tbl[i].ra1; rd_addr2 = tbl[i].ra2;
            step();
            chk($sformatf("tbl%0d_rd1", i), rd1_a, tbl[i].e1);
            chk($sformatf("tbl%0d_rd2", i), rd2_a, tbl[i].e2);
        end
        wr_en = 1'b0;

        // Clear sweep with a repeated request and a write landing mid-sweep.
        fill_index();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        na = 0; nb = 0; da = 0; db = 0;
        for (int c = 0; c < 40; c++) begin
            na += int'(busy_a); nb += int'(busy_b);
            da += int'(done_a); db += int'(done_b);
            clr_req  = (c == 10);
            wr_en    = (c == 4);
            wr_addr  = 5'd7;
            wr_data  = 32'h00000777;
            rd_addr1 = 5'($urandom_range(31));
            rd_addr2 = 5'($urandom_range(31));
            step();
        end
        clr_req = 1'b0; wr_en = 1'b0;
        chk("busy_cycles_a", 32'(na), 32'd32);
        chk("busy_cycles_b", 32'(nb), 32'd20);
        chk("done_pulses_a", 32'(da), 32'd1);
        chk("done_pulses_b", 32'(db), 32'd1);
        rd_addr1 = 5'd7; rd_addr2 = 5'd31;
        step();
        chk("reg7_after_sweep", rd1_a, 32'h0);
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            step();
        end

        // Asynchronous reset of the 20-entry instance ten cycles into its sweep.
        fill_index();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int c = 0; c < 9; c++) step();
        rst_b_n = 1'b0;
        #1;
        chk("busy_b_async_rst", 32'(busy_b), 32'd0);
        chk("done_b_async_rst", 32'(done_b), 32'd0);
        chk("rd1_b_async_rst", rd1_b, 32'h0);
        model_reset(1);
        step();
        rst_b_n = 1'b1;
        db = 0;
        for (int c = 0; c < 40; c++) begin
            db += int'(done_b);
            step();
        end
        chk("no_done_after_rst_b", 32'(db), 32'd0);
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            step();
        end
        rd_addr1 = 5'd25; rd_addr2 = 5'd19;
        step();
        chk("b_addr25_zero", rd1_b, 32'h0);

        for (int n = 0; n < 1500; n++) begin
            wr_en    = ($urandom_range(3) != 0);
            wr_addr  = 5'($urandom_range(31));
            wr_data  = $urandom;
            rd_addr1 = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom_range(31));
            rd_addr2 = 5'($urandom_range(31));
            clr_req  = ($urandom_range(59) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
